// File: rtl/pkt_pkg.sv
// pkt_pkg: shared serializer state encoding and packet geometry
package pkt_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, GAP} xmt_state_t;
  localparam int PCKT_BYTES = 3;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/packet_xmt_manchester_tx.sv
// manchester_TX: one-byte Manchester serializer with START/DATA/GAP framing
module manchester_TX
  import pkt_pkg::*;
#(
  parameter int HALF_BIT  = 8,
  parameter int GAP_CELLS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_go,
  input  logic [BYTE_W-1:0] data,
  output logic              TX,
  output logic              byte_done
);
  localparam int HW = $clog2(HALF_BIT);
  localparam int GW = $clog2(GAP_CELLS + 1);
  localparam int BW = $clog2(BYTE_W);
  xmt_state_t state, state_n;
  logic [HW-1:0] half_cnt, half_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic phase, phase_n, half_end, cell_end, tx_n;
  // Next-state and counter decode; TX is decoded from the next state so the flop drives a clean line
  always_comb begin
    half_end  = half_cnt == HW'(HALF_BIT - 1);
    cell_end  = half_end && phase;
    byte_done = state == GAP && cell_end && gap_cnt == GW'(GAP_CELLS - 1);
    state_n   = state;
    bit_n     = bit_cnt;
    gap_n     = gap_cnt;
    half_n    = (state == IDLE || half_end) ? '0 : half_cnt + 1'b1;
    phase_n   = state != IDLE && (phase ^ half_end);
    case (state)
      IDLE:  state_n = byte_go ? START : IDLE;
      START: state_n = cell_end ? DATA : START;
      DATA: if (cell_end) begin
        bit_n   = bit_cnt + 1'b1;
        state_n = bit_cnt == BW'(BYTE_W - 1) ? GAP : DATA;
      end
      GAP: if (cell_end) begin
        gap_n   = byte_done ? '0 : gap_cnt + 1'b1;
        state_n = byte_done ? (byte_go ? START : IDLE) : GAP;
      end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START || (state_n == DATA && (data[BW'(BYTE_W - 1) - bit_n] ~^ phase_n));
  end
  // State, counters and the TX line flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      TX       <= 1'b0;
    end else begin
      state    <= state_n;
      half_cnt <= half_n;
      phase    <= phase_n;
      bit_cnt  <= bit_n;
      gap_cnt  <= gap_n;
      TX       <= tx_n;
    end
  end
endmodule

// File: rtl/packet_xmt.sv
// packet_xmt: serializes a 24-bit packet as three Manchester byte frames, high byte first
module packet_xmt
  import pkt_pkg::*;
#(
  parameter int HALF_BIT  = 8,
  parameter int GAP_CELLS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         send,
  input  logic [PCKT_BYTES*BYTE_W-1:0] pckt,
  output logic                         TX,
  output logic                         tx_busy,
  output logic                         pckt_sent
);
  localparam int PW = PCKT_BYTES * BYTE_W;
  logic [PW-1:0] shift;
  logic [1:0] byte_cnt;
  logic byte_go, byte_done, last;
  // A byte starts on an accepted send or when a non-final byte finishes its gap
  always_comb begin
    last    = byte_cnt == 2'(PCKT_BYTES - 1);
    byte_go = (!tx_busy && send) || (byte_done && !last);
  end
  manchester_TX #(.HALF_BIT(HALF_BIT), .GAP_CELLS(GAP_CELLS)) u_ser (
    .clk(clk),
    .rst(rst),
    .byte_go(byte_go),
    .data(shift[PW-1 -: BYTE_W]),
    .TX(TX),
    .byte_done(byte_done)
  );
  // Packet latch, byte sequencing and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      shift     <= '0;
      byte_cnt  <= '0;
      tx_busy   <= 1'b0;
      pckt_sent <= 1'b0;
    end else begin
      pckt_sent <= 1'b0;
      if (!tx_busy && send) begin
        shift    <= pckt;
        byte_cnt <= '0;
        tx_busy  <= 1'b1;
      end else if (byte_done) begin
        shift     <= shift << BYTE_W;
        byte_cnt  <= last ? '0 : byte_cnt + 1'b1;
        tx_busy   <= !last;
        pckt_sent <= last;
      end
    end
  end
endmodule

// File: tb/tb_packet_xmt.sv
// tb_packet_xmt: directed self-checking bench for packet_xmt at HALF_BIT=8, GAP_CELLS=2
module tb_packet_xmt;
  localparam int CELL = 16;
  localparam int FRAME = 11 * CELL;
  localparam int PKT = 3 * FRAME;
  logic clk = 0, rst = 1, send = 0;
  logic [23:0] pckt = '0;
  logic tx, tx_busy, pckt_sent;
  int n_vec = 0, n_err = 0;
  logic [23:0] rx;

  packet_xmt #(.HALF_BIT(8), .GAP_CELLS(2)) dut (
    .clk(clk), .rst(rst), .send(send), .pckt(pckt),
    .TX(tx), .tx_busy(tx_busy), .pckt_sent(pckt_sent)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_tx(input logic [23:0] p, input int k);
    int k0 = k - 1;
    int b = k0 / FRAME;
    int r = k0 % FRAME;
    int c = r / CELL;
    int h = (r % CELL) / 8;
    logic [7:0] by = p[23 - 8*b -: 8];
    logic bt;
    if (c == 0) return 1'b1;
    if (c > 8) return 1'b0;
    bt = by[8 - c];
    return h != 0 ? bt : ~bt;
  endfunction

  task automatic send_pkt(input logic [23:0] p);
    pckt = p;
    send = 1;
    step();
    send = 0;
  endtask

  task automatic check_clock(input logic [23:0] p, input int k);
    int r = (k - 1) % FRAME;
    int c = r / CELL;
    chk($sformatf("tx@%0d", k), 24'(tx), 24'(exp_tx(p, k)));
    chk($sformatf("busy@%0d", k), 24'(tx_busy), 24'd1);
    chk($sformatf("sent@%0d", k), 24'(pckt_sent), 24'd0);
    if (c >= 1 && c <= 8 && r % CELL == 12) rx = {rx[22:0], tx};
  endtask

  task automatic run_full(input logic [23:0] p, input int ign_at);
    rx = '0;
    send_pkt(p);
    for (int k = 1; k <= PKT; k++) begin
      check_clock(p, k);
      if (k == ign_at) begin
        pckt = 24'hFFFFFF;
        send = 1;
      end
      step();
      send = 0;
    end
    chk("done_sent", 24'(pckt_sent), 24'd1);
    chk("done_busy", 24'(tx_busy), 24'd0);
    chk("done_tx", 24'(tx), 24'd0);
    chk("decode", rx, p);
  endtask

  initial begin
    step();
    step();
    rst = 0;
    chk("rst_tx", 24'(tx), 24'd0);
    chk("rst_busy", 24'(tx_busy), 24'd0);
    chk("rst_sent", 24'(pckt_sent), 24'd0);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_tx", 24'(tx), 24'd0);
      chk("idle_busy", 24'(tx_busy), 24'd0);
      chk("idle_sent", 24'(pckt_sent), 24'd0);
    end
    rx = '0;
    send_pkt(24'hA53C01);
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("a5_head@%0d", k), 24'(tx), 24'((k <= 16) || (k > 24)));
      step();
    end
    chk("a5_cell1_tail", 24'(tx), 24'd1);
    rst = 1;
    step();
    rst = 0;
    step();
    run_full(24'hA53C01, 100);
    run_full(24'h123456, 0);
    step();
    chk("b2b_sent_once", 24'(pckt_sent), 24'd0);
    for (int i = 0; i < 10; i++) step();
    send_pkt(24'hA53C01);
    for (int k = 1; k < 200; k++) begin
      check_clock(24'hA53C01, k);
      step();
    end
    rst = 1;
    pckt = 24'hFFFFFF;
    send = 1;
    step();
    rst = 0;
    send = 0;
    chk("abort_tx", 24'(tx), 24'd0);
    chk("abort_busy", 24'(tx_busy), 24'd0);
    for (int i = 0; i < 400; i++) begin
      step();
      chk("abort_idle_tx", 24'(tx), 24'd0);
      chk("abort_idle_sent", 24'(pckt_sent), 24'd0);
      chk("abort_idle_busy", 24'(tx_busy), 24'd0);
    end
    run_full(24'h000000, 0);
    step();
    chk("final_sent", 24'(pckt_sent), 24'd0);
    chk("final_tx", 24'(tx), 24'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
